// File: rtl/riscv_if_pkg.sv
// Shared types and line geometry for the instruction-fetch responder.
package riscv_if_pkg;

  localparam int LINE_BYTES = 8;
  localparam int LINE_OFS_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } imem_state_t;

endpackage

// File: rtl/imem_responder_if.sv
// Instruction memory bus: request/grant handshake plus a single-beat doubleword response.
interface imem_responder_if #(
  parameter int addr_w = 48,
  parameter int data_w = 64
);

  logic              mem_req;
  logic [addr_w-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [data_w-1:0] mem_rdata;
  logic              mem_err;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

endinterface

// File: rtl/imem_responder.sv
// Fetch-side responder: zero-latency hits from a one-doubleword line buffer,
// misses refilled by one request/grant/response transaction at a time.
module imem_responder
  import riscv_if_pkg::*;
#(
  parameter int addr_w = 48,
  parameter int data_w = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [addr_w-1:0] pc,
  input  logic              trap_if,
  input  logic              fence_i,
  output logic [31:0]       instr,
  output logic              ready,
  output logic              fetch_fault,
  imem_responder_if.master  bus
);

  localparam int TAG_W = addr_w - LINE_OFS_W;

  imem_state_t       state_r;
  imem_state_t       state_nxt_s;
  logic              buf_valid_r;
  logic [TAG_W-1:0]  buf_tag_r;
  logic [data_w-1:0] buf_data_r;
  logic              buf_err_r;
  logic              discard_r;
  logic              hit_s;
  logic              unused_pc_s;

  // Instruction-aligned low PC bits never select anything inside the line.
  assign unused_pc_s = ^pc[LINE_OFS_W-2:0];

  // Hit detection and the zero-latency instruction mux.
  always_comb begin
    hit_s       = 1'b0;
    ready       = 1'b0;
    fetch_fault = 1'b0;
    instr       = 32'd0;
    if (buf_valid_r && (buf_tag_r == pc[addr_w-1:LINE_OFS_W]) &&
        !trap_if && !fence_i && (state_r == IDLE)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
    if (hit_s) begin
      ready       = 1'b1;
      fetch_fault = buf_err_r;
      if (buf_err_r) begin
        instr = 32'd0;
      end else if (pc[LINE_OFS_W-1]) begin
        instr = buf_data_r[data_w-1:32];
      end else begin
        instr = buf_data_r[31:0];
      end
    end else begin
      ready = 1'b0;
    end
  end

  // Next-state logic for the miss transaction.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!hit_s && !trap_if && !fence_i) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bus request registers and line buffer; a fence during a transaction
  // lets it finish but drops its data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= {addr_w{1'b0}};
      buf_valid_r  <= 1'b0;
      buf_tag_r    <= {TAG_W{1'b0}};
      buf_data_r   <= {data_w{1'b0}};
      buf_err_r    <= 1'b0;
      discard_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (fence_i) begin
            buf_valid_r <= 1'b0;
          end else if (!trap_if && !hit_s) begin
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= {pc[addr_w-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
            discard_r    <= 1'b0;
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
          end
          if (fence_i) begin
            discard_r   <= 1'b1;
            buf_valid_r <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid && !discard_r && !fence_i) begin
            buf_tag_r   <= bus.mem_addr[addr_w-1:LINE_OFS_W];
            buf_data_r  <= bus.mem_rdata;
            buf_err_r   <= bus.mem_err;
            buf_valid_r <= 1'b1;
          end
          if (fence_i) begin
            discard_r   <= 1'b1;
            buf_valid_r <= 1'b0;
          end
        end
        default: begin
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-side responder for the fetch stage. Takes the fetch PC and returns the 32-bit instruction with a `ready` strobe. Hits are served combinationally from a one-doubleword line buffer. Misses run a request/grant/response transaction on the 64-bit instruction memory bus and refill the buffer. It sits between fetch stage 1 and the instruction memory / L1 interface.

## Interface
Parameters:
- `addr_w`, 48: PC and memory address width.
- `data_w`, 64: memory bus data width; the line is fixed at 8 bytes (two instructions).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high; all state clears immediately on assertion.
- `pc` in `addr_w`: fetch PC from stage 1.
- `trap_if` in 1: PC misaligned; no lookup, no request.
- `fence_i` in 1: invalidate line buffer (single-cycle pulse).
- `instr` out 32: instruction for `pc`; 0 when `ready`=0.
- `ready` out 1: `instr`/`fetch_fault` valid for the current `pc` this cycle.
- `fetch_fault` out 1: access fault for `pc`; qualified by `ready`.
- `mem_req` out 1: bus request, registered.
- `mem_addr` out `addr_w`: doubleword-aligned address, registered.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: response data valid.
- `mem_rdata` in `data_w`: response doubleword.
- `mem_err` in 1: response error; qualified by `mem_rvalid`.

## Operation
- Buffer state: `buf_valid`, `buf_tag` = `addr[addr_w-1:3]`, `buf_data[63:0]`, `buf_err`.
- `hit` = `buf_valid` & (`buf_tag` == `pc[addr_w-1:3]`) & !`trap_if` & !`fence_i` & (state==IDLE).
- On `hit`: `ready`=1.
  - `instr` = `pc[2]` ? `buf_data[63:32]` : `buf_data[31:0]`.
  - `fetch_fault` = `buf_err`.
  - If `buf_err`, `instr`=0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE → REQ when !`hit` & !`trap_if` & !`fence_i`. At the same edge: `mem_req`←1, `mem_addr`←{`pc[addr_w-1:3]`,3'b0}, `discard`←0.
  - REQ: hold `mem_req`=1 and keep `mem_addr` stable until `mem_gnt`. On `mem_gnt`: `mem_req`←0, go to WAIT.
  - WAIT: on `mem_rvalid`, go to IDLE.
    - If !`discard`: `buf_tag`←`mem_addr[addr_w-1:3]`, `buf_data`←`mem_rdata`, `buf_err`←`mem_err`, `buf_valid`←1.
    - If `discard`: the buffer is left untouched.
  - `mem_rvalid` in IDLE or REQ is ignored. Exactly one transaction is outstanding at a time.
- `pc` may change in REQ/WAIT (mispredict redirect). The transaction always completes for its latched address; there is no retraction. The fill is kept because it is still correct memory content. The new `pc` is looked up in IDLE afterwards.
- `fence_i`:
  - In IDLE: `buf_valid`←0 at the edge, and `ready`=0 that cycle.
  - In REQ/WAIT: `discard`←1 and `buf_valid`←0.
  - Coinciding with `mem_rvalid` in WAIT: the data is discarded.
- `ready` is 0 in REQ and WAIT.
- Reset values: `ready`=0, `instr`=0, `fetch_fault`=0, `mem_req`=0, `mem_addr`=0, `buf_valid`=0, `buf_err`=0, `discard`=0, state=IDLE.
- Reset mid-transaction abandons it. The bus side must also be reset, so any stale `mem_rvalid` arriving in IDLE is ignored.

## Timing
- Hit latency is 0: `ready` is asserted in the same cycle `pc` is presented.
- Miss timeline:
  - Cycle 0: miss detected.
  - Cycle 1: `mem_req`=1.
  - `mem_gnt` in cycle g ≥ 1.
  - `mem_rvalid` in cycle r > g.
  - Fill at the end of r; `ready` in r+1.
- Minimum miss penalty is 3 cycles (g=1, r=2).
- A sequential `pc`+4 within the same doubleword hits with no further stall.
- `mem_req` deasserts in the cycle after `mem_gnt`.

## Structure
- Package `riscv_if_pkg`: `imem_state_t` enum {IDLE, REQ, WAIT}, `LINE_BYTES`=8, `LINE_OFS_W`=3.
- Single module, no sub-modules. Buffer, FSM and output mux live in one file.

## Test plan
- Reset, then `pc`=0x0. Required: `ready`=0; `mem_req`=1 with `mem_addr`=0x0 in cycle 1. Return `mem_gnt` in cycle 1 and `mem_rvalid` with `mem_rdata`=0x00500093_00000013 in cycle 2. Then `ready`=1 with `instr`=0x00000013 in cycle 3. `pc`=0x4 next gives `ready`=1, `instr`=0x00500093 with no bus activity.
- Hold `mem_gnt`=0 for 5 cycles. Required: `mem_req` stays 1 and `mem_addr` stays stable throughout, and `ready`=0 the whole time.
- Redirect `pc` 0x8→0x100 during WAIT. Required: the 0x8 line fills, then a new request is issued with `mem_addr`=0x100.
- Pulse `fence_i` in WAIT. Required: the response is discarded, `buf_valid`=0, and re-presenting the same `pc` issues a new request.
- Set `mem_err`=1 with `mem_rvalid`. Required: `ready`=1, `fetch_fault`=1, `instr`=0 in the next cycle.
- Hold `trap_if`=1 with `pc`=0x2. Required: no `mem_req`, `ready`=0. Also assert `reset` in WAIT and check that all outputs go to 0 asynchronously.
